// File: rtl/cv32e40s_data_bus_arbiter_if.sv
// Bundle of the two requester-side OBI data channels, the shared bus-side
// channel and the status flags of the data bus arbiter.
interface cv32e40s_data_bus_arbiter_if;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } obi_data_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } obi_data_resp_t;

   logic           valid0_i;
   obi_data_req_t  trans0_i;
   logic           ready0_o;
   logic           valid1_i;
   obi_data_req_t  trans1_i;
   logic           ready1_o;
   logic           valid_o;
   obi_data_req_t  trans_o;
   logic           ready_i;
   logic           resp_valid_i;
   obi_data_resp_t resp_i;
   logic           resp_valid0_o;
   logic           resp_valid1_o;
   obi_data_resp_t resp_o;
   logic           busy_o;
   logic           protocol_err_o;

   // Arbiter's view.
   modport master (
      input  valid0_i, trans0_i, valid1_i, trans1_i, ready_i, resp_valid_i, resp_i,
      output ready0_o, ready1_o, valid_o, trans_o, resp_valid0_o, resp_valid1_o,
             resp_o, busy_o, protocol_err_o
   );

   // Environment's view (requesters plus bus).
   modport slave (
      output valid0_i, trans0_i, valid1_i, trans1_i, ready_i, resp_valid_i, resp_i,
      input  ready0_o, ready1_o, valid_o, trans_o, resp_valid0_o, resp_valid1_o,
             resp_o, busy_o, protocol_err_o
   );

endinterface

// File: rtl/cv32e40s_data_bus_arbiter.sv
// Two-requester arbiter for the data-side OBI channel. Round-robin grant,
// grant held while the bus stalls a presented request, and an in-order owner
// FIFO that steers each response back to the requester that issued it.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_OPEN  | no request pending on the bus, grant chosen freely
// ST_HOLD  | previous cycle's request was stalled, grant pinned to grant_q
module cv32e40s_data_bus_arbiter #(
   parameter int DEPTH     = 2,
   parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
   input logic                          clk,
   input logic                          rst,
   cv32e40s_data_bus_arbiter_if.master  bus
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {ST_OPEN, ST_HOLD} state_e;

   state_e               state_q, state_d;
   logic                 grant_q;
   logic                 rr_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
   logic [DEPTH-1:0]     owner_q;

   logic grant;
   logic full;
   logic req_valid;
   logic push;
   logic pop;
   logic head;
   logic cnt_nz;

   assign full   = (cnt_q == CNT_WIDTH'(DEPTH));
   assign cnt_nz = (cnt_q != '0);
   assign head   = owner_q[rd_ptr_q];

   // Grant selection, bus-side valid and lock next state.
   always_comb begin
      grant     = 1'b0;
      req_valid = 1'b0;
      state_d   = ST_OPEN;
      if (state_q == ST_HOLD) begin
         grant = grant_q;
      end else if (bus.valid0_i && bus.valid1_i) begin
         grant = rr_q;
      end else if (bus.valid1_i) begin
         grant = 1'b1;
      end
      req_valid = !full && (grant ? bus.valid1_i : bus.valid0_i);
      if (req_valid && !bus.ready_i) begin
         state_d = ST_HOLD;
      end
   end

   assign push = req_valid && bus.ready_i;
   assign pop  = bus.resp_valid_i && cnt_nz;

   // Lock state, held grant and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_OPEN;
         grant_q <= 1'b0;
         rr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant;
         if (push) begin
            rr_q <= !grant;
         end
      end
   end

   // Owner FIFO and outstanding count; a push blocked when full keeps cnt_q in range.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         owner_q  <= '0;
      end else begin
         if (push) begin
            owner_q[wr_ptr_q] <= grant;
            wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            cnt_q <= cnt_q + 1'b1;
         end else if (pop && !push) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   // Control outputs are forced low while reset is held; payloads pass through.
   assign bus.valid_o        = !rst && req_valid;
   assign bus.trans_o        = grant ? bus.trans1_i : bus.trans0_i;
   assign bus.ready0_o       = !rst && !grant && bus.ready_i && !full;
   assign bus.ready1_o       = !rst &&  grant && bus.ready_i && !full;
   assign bus.resp_valid0_o  = !rst && pop && !head;
   assign bus.resp_valid1_o  = !rst && pop &&  head;
   assign bus.resp_o         = bus.resp_i;
   assign bus.busy_o         = !rst && (cnt_nz || bus.valid0_i || bus.valid1_i);
   assign bus.protocol_err_o = !rst && bus.resp_valid_i && !cnt_nz;

endmodule

// File: tb/tb_cv32e40s_data_bus_arbiter.sv
module tb_cv32e40s_data_bus_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;

   cv32e40s_data_bus_arbiter_if bus ();

   cv32e40s_data_bus_arbiter #(.DEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] ADDR0 = 32'h1000_0000;
   localparam logic [31:0] ADDR1 = 32'h2000_0004;

   typedef struct {
      string      name;
      logic [4:0] in;   // v0 v1 ready rv rerr
      logic [7:0] exp;  // valid sel r0 r1 rv0 rv1 perr busy
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input string name, input logic [4:0] in, input logic [7:0] exp);
      vec_t v;
      v.name = name;
      v.in   = in;
      v.exp  = exp;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic [4:0] in);
      bus.valid0_i      = in[4];
      bus.valid1_i      = in[3];
      bus.ready_i       = in[2];
      bus.resp_valid_i  = in[1];
      bus.resp_i.err    = in[0];
      bus.resp_i.rdata  = {27'h0, in};
   endtask

   task automatic check_row(input vec_t v);
      check({v.name, ".valid_o"},        32'(bus.valid_o),        32'(v.exp[7]));
      if (v.exp[7]) begin
         check({v.name, ".trans_o.addr"}, bus.trans_o.addr, v.exp[6] ? ADDR1 : ADDR0);
      end
      check({v.name, ".ready0_o"},       32'(bus.ready0_o),       32'(v.exp[5]));
      check({v.name, ".ready1_o"},       32'(bus.ready1_o),       32'(v.exp[4]));
      check({v.name, ".resp_valid0_o"},  32'(bus.resp_valid0_o),  32'(v.exp[3]));
      check({v.name, ".resp_valid1_o"},  32'(bus.resp_valid1_o),  32'(v.exp[2]));
      check({v.name, ".protocol_err_o"}, 32'(bus.protocol_err_o), 32'(v.exp[1]));
      check({v.name, ".busy_o"},         32'(bus.busy_o),         32'(v.exp[0]));
      check({v.name, ".resp_o.err"},     32'(bus.resp_o.err),     32'(v.in[0]));
   endtask

   initial begin
      // alternation 0,1,0,1 from reset with responses routed in order
      add("B1", 5'b11100, 8'b1010_0001);
      add("B2", 5'b11110, 8'b1101_1001);
      add("B3", 5'b11110, 8'b1010_0101);
      add("B4", 5'b11110, 8'b1101_1001);
      add("B5", 5'b00011, 8'b0000_0101);
      // single transfer on port 0, response next cycle, count back to 0
      add("A1", 5'b10100, 8'b1010_0001);
      add("A2", 5'b00010, 8'b0000_1001);
      add("A3", 5'b00000, 8'b0000_0000);
      // stall: port 0 held while rr points at port 1, then port 1 wins
      add("C1", 5'b10000, 8'b1000_0001);
      add("C2", 5'b11000, 8'b1000_0001);
      add("C3", 5'b11000, 8'b1000_0001);
      add("C4", 5'b11100, 8'b1010_0001);
      add("C5", 5'b11100, 8'b1101_0001);
      // full: blocked until a pop, accepted the cycle after the pop
      add("D1", 5'b11100, 8'b0000_0001);
      add("D2", 5'b11110, 8'b0000_1001);
      add("D3", 5'b11100, 8'b1010_0001);
      // outstanding 1,0,1 delivered in order, err passes through
      add("E1", 5'b01111, 8'b0000_0101);
      add("E2", 5'b01110, 8'b1101_1001);
      add("E3", 5'b00011, 8'b0000_0101);
      // response with nothing outstanding
      add("F1", 5'b00010, 8'b0000_0010);
      add("F2", 5'b00000, 8'b0000_0000);

      bus.trans0_i = '0;
      bus.trans1_i = '0;
      bus.trans0_i.addr  = ADDR0;
      bus.trans0_i.wdata = 32'hA5A5_0000;
      bus.trans0_i.be    = 4'hF;
      bus.trans1_i.addr  = ADDR1;
      bus.trans1_i.we    = 1'b1;
      bus.trans1_i.wdata = 32'h5A5A_1111;
      bus.trans1_i.be    = 4'h3;
      drive(5'b00000);

      // reset state
      #2;
      check("rst.valid_o", 32'(bus.valid_o), 32'd0);
      check("rst.busy_o",  32'(bus.busy_o),  32'd0);
      check("rst.perr",    32'(bus.protocol_err_o), 32'd0);
      drive(5'b10110);
      #1;
      check("rst.gated.valid_o",  32'(bus.valid_o),       32'd0);
      check("rst.gated.ready0_o", 32'(bus.ready0_o),      32'd0);
      check("rst.gated.rv0",      32'(bus.resp_valid0_o), 32'd0);
      check("rst.gated.perr",     32'(bus.protocol_err_o), 32'd0);
      check("rst.trans_pass",     bus.trans_o.addr,       ADDR0);
      drive(5'b00000);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].in);
         #1;
         check_row(vecs[i]);
      end

      // reset pulsed with two transfers outstanding
      @(negedge clk);
      drive(5'b10100);
      #1;
      check("R1.ready0_o", 32'(bus.ready0_o), 32'd1);
      @(negedge clk);
      drive(5'b01100);
      #1;
      check("R2.ready1_o", 32'(bus.ready1_o), 32'd1);
      @(negedge clk);
      drive(5'b00000);
      #1;
      check("R3.busy_pre", 32'(bus.busy_o), 32'd1);
      rst = 1'b1;
      #1;
      check("R3.busy_in_rst", 32'(bus.busy_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("R4.busy_after", 32'(bus.busy_o), 32'd0);
      @(negedge clk);
      drive(5'b00010);
      #1;
      check("R5.perr", 32'(bus.protocol_err_o), 32'd1);
      check("R5.rv0",  32'(bus.resp_valid0_o),  32'd0);
      check("R5.rv1",  32'(bus.resp_valid1_o),  32'd0);
      @(negedge clk);
      drive(5'b00000);
      #1;
      check("R6.busy", 32'(bus.busy_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
